// File: rtl/reg_arbiter.sv
// Four-requester round-robin arbiter guarding a shared W-bit register.
// Define REG_ARBITER_LOCK_EN to add the LOCK port for back-to-back locked writes.
module reg_arbiter #(
    parameter int W = 8
) (
    input  logic           CK,
    input  logic           RST,
    input  logic [3:0]     REQ,
    input  logic [4*W-1:0] WD,
`ifdef REG_ARBITER_LOCK_EN
    input  logic           LOCK,
`endif
    output logic [3:0]     GNT,
    output logic           ACK,
    output logic [W-1:0]   Q,
    output logic [1:0]     OWN,
    output logic           BUSY
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   gnt_q,   gnt_d;
    logic         ack_q,   ack_d;
    logic [W-1:0] q_q,     q_d;
    logic [1:0]   own_q,   own_d;
    logic [1:0]   ptr_q,   ptr_d;
    logic [1:0]   gidx_q,  gidx_d;

    logic [1:0]   win;
    logic [1:0]   cand;
    logic         found;
    logic         hold;

    // Search starts just past the last winner, so the last winner ranks lowest.
    always_comb begin
        win   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && REQ[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

`ifdef REG_ARBITER_LOCK_EN
    assign hold = LOCK && REQ[gidx_q];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        q_d     = q_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (REQ != 4'b0000) begin
                    gidx_d  = win;
                    gnt_d   = 4'b0001 << win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (REQ[gidx_q]) begin
                    q_d     = WD[gidx_q*W +: W];
                    own_d   = gidx_q;
                    ptr_d   = gidx_q;
                    ack_d   = 1'b1;
                    state_d = WRITE;
                end else begin
                    gnt_d   = 4'b0000;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                ack_d = 1'b0;
                if (hold) begin
                    state_d = GRANT;
                end else begin
                    gnt_d   = 4'b0000;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            ack_q   <= 1'b0;
            q_q     <= '0;
            own_q   <= 2'd0;
            ptr_q   <= 2'd3;
            gidx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    assign GNT  = gnt_q;
    assign ACK  = ack_q;
    assign Q    = q_q;
    assign OWN  = own_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_reg_arbiter.sv
// Scoreboard bench for reg_arbiter: expected writes queued at stimulus time,
// checked against Q/OWN whenever ACK pulses.
module tb_reg_arbiter;

    localparam int W = 8;

    logic           CK;
    logic           RST;
    logic [3:0]     REQ;
    logic [4*W-1:0] WD;
`ifdef REG_ARBITER_LOCK_EN
    logic           LOCK;
`endif
    logic [3:0]     GNT;
    logic           ACK;
    logic [W-1:0]   Q;
    logic [1:0]     OWN;
    logic           BUSY;

    typedef struct packed {
        logic [7:0] q;
        logic [1:0] own;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev_ack = 1'b0;

    reg_arbiter #(.W(W)) dut (
        .CK  (CK),
        .RST (RST),
        .REQ (REQ),
        .WD  (WD),
`ifdef REG_ARBITER_LOCK_EN
        .LOCK(LOCK),
`endif
        .GNT (GNT),
        .ACK (ACK),
        .Q   (Q),
        .OWN (OWN),
        .BUSY(BUSY)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic push(input logic [7:0] q, input logic [1:0] own);
        exp_t e;
        e.q   = q;
        e.own = own;
        sb.push_back(e);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    // Output monitor runs on the falling edge, away from state changes.
    always @(negedge CK) begin
        if (ACK) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_q", Q, e.q);
                chk("ack_own", OWN, e.own);
            end
        end
        if ($countones(GNT) > 1) chk("gnt_onehot", GNT, 0);
        if (prev_ack && ACK) chk("ack_twice", 1, 0);
        prev_ack <= ACK;
    end

    initial begin
        RST = 1'b1;
        REQ = 4'b0000;
        WD  = '0;
`ifdef REG_ARBITER_LOCK_EN
        LOCK = 1'b0;
`endif
        #1;
        chk("rst_q", Q, 0);
        chk("rst_gnt", GNT, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_own", OWN, 0);
        @(negedge CK);
        RST = 1'b0;

        // single write from requester 2
        REQ = 4'b0100;
        WD[23:16] = 8'hA5;
        push(8'hA5, 2'd2);
        tick();
        chk("sw_gnt1", GNT, 4'b0100);
        chk("sw_busy", BUSY, 1);
        tick();
        chk("sw_gnt2", GNT, 4'b0100);
        chk("sw_ack", ACK, 1);
        chk("sw_q", Q, 8'hA5);
        chk("sw_own", OWN, 2);
        REQ = 4'b0000;
        tick();
        chk("sw_gnt_end", GNT, 0);
        chk("sw_ack_end", ACK, 0);
        chk("sw_idle", BUSY, 0);
        chk("sw_sb", sb.size(), 0);

        // asynchronous reset mid-cycle
        #3 RST = 1'b1;
        #1;
        chk("ar_q", Q, 0);
        chk("ar_gnt", GNT, 0);
        chk("ar_ack", ACK, 0);
        chk("ar_busy", BUSY, 0);
        #2 RST = 1'b0;

        // round robin with all requesters held
        WD  = {8'h44, 8'h33, 8'h22, 8'h11};
        REQ = 4'b1111;
        push(8'h11, 2'd0);
        push(8'h22, 2'd1);
        push(8'h33, 2'd2);
        push(8'h44, 2'd3);
        push(8'h11, 2'd0);
        drain(40);
        REQ = 4'b0000;
        tick();
        chk("rr_idle", BUSY, 0);

        // abort leaves pointer untouched
        RST = 1'b1;
        #1 RST = 1'b0;
        WD  = '0;
        REQ = 4'b0010;
        tick();
        chk("ab_gnt", GNT, 4'b0010);
        REQ = 4'b0000;
        tick();
        chk("ab_gnt0", GNT, 0);
        chk("ab_ack", ACK, 0);
        chk("ab_idle", BUSY, 0);
        chk("ab_q", Q, 0);
        REQ = 4'b0011;
        WD[7:0] = 8'h5A;
        push(8'h5A, 2'd0);
        tick();
        chk("ab_regnt", GNT, 4'b0001);
        drain(10);
        REQ = 4'b0000;
        tick();

        // reset during GRANT must suppress the write
        RST = 1'b1;
        #1 RST = 1'b0;
        WD[7:0] = 8'h3C;
        REQ = 4'b0001;
        tick();
        chk("mt_gnt", GNT, 4'b0001);
        #2 RST = 1'b1;
        #1;
        chk("mt_gnt0", GNT, 0);
        chk("mt_busy", BUSY, 0);
        #2 RST = 1'b0;
        REQ = 4'b0000;
        tick();
        tick();
        chk("mt_q", Q, 0);
        chk("mt_idle", BUSY, 0);

`ifdef REG_ARBITER_LOCK_EN
        // locked back-to-back writes from requester 3 while requester 0 waits
        RST = 1'b1;
        #1 RST = 1'b0;
        WD  = '0;
        WD[31:24] = 8'h11;
        REQ  = 4'b1000;
        LOCK = 1'b1;
        push(8'h11, 2'd3);
        push(8'h22, 2'd3);
        tick();
        chk("lk_gnt", GNT, 4'b1000);
        tick();
        chk("lk_ack1", ACK, 1);
        REQ = 4'b1001;
        WD[31:24] = 8'h22;
        WD[7:0]   = 8'h77;
        tick();
        chk("lk_hold", GNT, 4'b1000);
        chk("lk_noack", ACK, 0);
        tick();
        chk("lk_ack2", ACK, 1);
        chk("lk_q2", Q, 8'h22);
        LOCK = 1'b0;
        push(8'h77, 2'd0);
        tick();
        chk("lk_rel", GNT, 0);
        tick();
        chk("lk_req0", GNT, 4'b0001);
        drain(10);
        REQ = 4'b0000;
        tick();
`endif

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter: W, 8, data width of the shared register and of each requester's write-data slice.
REQ-002 Port: CK  input  1  clock; all state changes occur on its rising edge.
REQ-003 Port: RST  input  1  reset; asynchronous, active-high.
REQ-004 Port: REQ  input  4  write request, one bit per requester 0..3.
REQ-005 Port: WD  input  4*W  packed write data; requester i occupies bits [i*W +: W].
REQ-006 Port: GNT  output  4  registered one-hot grant; all zero when no requester is granted.
REQ-007 Port: ACK  output  1  registered single-cycle pulse marking the cycle in which Q takes the new value.
REQ-008 Port: Q  output  W  shared register contents.
REQ-009 Port: OWN  output  2  index of the requester that last wrote Q.
REQ-010 Port: BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and WRITE.
REQ-012 IDLE, at an edge with REQ != 0: winner is the first set REQ bit searching PTR+1, PTR+2, PTR+3, PTR (mod 4); GNT becomes one-hot of the winner; next state is GRANT.
REQ-013 IDLE, at an edge with REQ == 0: GNT stays 0 and the state stays IDLE.
REQ-014 GRANT, at an edge with REQ[g] = 1 (g = granted index): Q <= WD slice g, OWN <= g, PTR <= g, ACK <= 1, next state is WRITE, GNT is held.
REQ-015 GRANT, at an edge with REQ[g] = 0 (abort): Q, OWN, PTR and ACK are unchanged, GNT <= 0, next state is IDLE.
REQ-016 WRITE, at the next edge: ACK <= 0, GNT <= 0, next state is IDLE (subject to REQ-026).
REQ-017 Latency: REQ first sampled high at edge k in IDLE gives GNT high after edge k, plus Q updated and ACK high after edge k+1. Minimum transaction length is 3 cycles.
REQ-018 REQ bits of non-granted requesters SHALL be ignored while the state is GRANT or WRITE; they are re-arbitrated in IDLE.
REQ-019 Because PTR moves to the last winner, a requester that holds REQ high continuously SHALL NOT win twice in a row while any other REQ bit is set.
REQ-020 WD SHALL be sampled only at the GRANT-to-WRITE edge. WD values at any other time have no effect.
REQ-021 GNT SHALL never have more than one bit set, and ACK SHALL never be high for two consecutive cycles (except as allowed by REQ-026).

Reset
REQ-022 While RST = 1, the block SHALL immediately and asynchronously set state = IDLE, GNT = 0, ACK = 0, Q = 0, OWN = 0, BUSY = 0 and PTR = 3, so requester 0 has first priority.
REQ-023 RST asserted in GRANT or WRITE SHALL abort the transaction; when RST asserts during GRANT, no write of Q occurs.
REQ-024 After RST falls, the first arbitration SHALL take place at the first rising edge of CK.

Configuration
REQ-025 Macro REG_ARBITER_LOCK_EN SHALL compile in an extra port: LOCK  input  1  hold-grant request from the granted requester.
REQ-026 With REG_ARBITER_LOCK_EN defined: in WRITE with LOCK = 1 and REQ[g] = 1, next state SHALL be GRANT, GNT SHALL stay one-hot g and ACK <= 0, giving back-to-back writes every 2 cycles. With LOCK = 0, REQ-016 applies.
REQ-027 With REG_ARBITER_LOCK_EN undefined: the LOCK port SHALL be absent and the behaviour SHALL be exactly REQ-011 to REQ-024.

Verification
REQ-028 Reset: assert RST mid-cycle -> outputs clear without waiting for an edge: Q = 8'h00, GNT = 0, ACK = 0, BUSY = 0.
REQ-029 Single write: REQ = 4'b0100, WD[23:16] = 8'hA5 -> GNT = 4'b0100 for 2 cycles, then Q = 8'hA5, OWN = 2, one ACK pulse, then IDLE.
REQ-030 Round-robin: REQ = 4'b1111 held with each WD slice distinct -> grants occur in order 0, 1, 2, 3, 0, and each ACK shows the matching Q.
REQ-031 Abort: REQ = 4'b0010, then REQ[1] dropped while in GRANT -> no ACK, Q unchanged, GNT = 0 after the next edge, PTR unchanged (the next REQ = 4'b0011 grants requester 0).
REQ-032 Mid-transaction reset: RST pulsed while in GRANT with WD slice = 8'h3C -> Q stays 8'h00 and the FSM is in IDLE.
REQ-033 LOCK (REG_ARBITER_LOCK_EN defined): requester 3 holds REQ and LOCK with WD slice 8'h11 then 8'h22 -> ACK every 2 cycles, Q = 8'h11 then 8'h22, and requester 0 (REQ held) is blocked until LOCK = 0.
